// File: rtl/ext_mem_arbiter.sv
// ext_mem_arbiter: shares one external data memory port between the instruction fetch and load/store masters
module ext_mem_arbiter #(
    parameter bit RR_EN  = 1'b1,
    parameter int ADDR_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              i_req_i,
    input  logic [ADDR_W-1:0] i_addr_i,
    output logic              i_gnt_o,
    output logic              i_rvalid_o,
    output logic [31:0]       i_rdata_o,
    input  logic              d_req_i,
    input  logic              d_we_i,
    input  logic [3:0]        d_be_i,
    input  logic [ADDR_W-1:0] d_addr_i,
    input  logic [31:0]       d_wdata_i,
    output logic              d_gnt_o,
    output logic              d_rvalid_o,
    output logic [31:0]       d_rdata_o,
    output logic              mem_req_o,
    output logic              write_enable_o,
    output logic [3:0]        byte_enable_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic [31:0]       write_data_o,
    input  logic [31:0]       read_data_i,
    input  logic              ready_i
);
    logic last_q, lock_q, lock_id_q, rsp_pend_q, rsp_id_q;
    logic act, sel, acc;

    // select a master (a stalled request owns the bus until accepted), drive the port and route the response
    always_comb begin
        act            = ~rst_i & (lock_q | i_req_i | d_req_i);
        sel            = lock_q ? lock_id_q : (i_req_i & d_req_i) ? (RR_EN ? ~last_q : 1'b1) : d_req_i;
        mem_req_o      = act;
        write_enable_o = act & sel & d_we_i;
        byte_enable_o  = ~act ? 4'h0 : sel ? d_be_i : 4'hF;
        addr_o         = ~act ? '0 : sel ? d_addr_i : i_addr_i;
        write_data_o   = (act & sel) ? d_wdata_i : 32'h0;
        acc            = act & ready_i;
        i_gnt_o        = acc & ~sel;
        d_gnt_o        = acc & sel;
        i_rvalid_o     = ~rst_i & rsp_pend_q & ~rsp_id_q;
        d_rvalid_o     = ~rst_i & rsp_pend_q & rsp_id_q;
        i_rdata_o      = i_rvalid_o ? read_data_i : 32'h0;
        d_rdata_o      = d_rvalid_o ? read_data_i : 32'h0;
    end

    // remember the last winner, hold the bus on a stall and mark the response due next cycle
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            last_q     <= 1'b1;
            lock_q     <= 1'b0;
            lock_id_q  <= 1'b0;
            rsp_pend_q <= 1'b0;
            rsp_id_q   <= 1'b0;
        end else begin
            rsp_pend_q <= acc;
            if (acc) begin
                last_q   <= sel;
                rsp_id_q <= sel;
                lock_q   <= 1'b0;
            end else if (act) begin
                lock_q    <= 1'b1;
                lock_id_q <= sel;
            end
        end
    end
endmodule

// File: tb/tb_ext_mem_arbiter.sv
// tb_ext_mem_arbiter: random and directed traffic from both masters, scoreboarded against a rule-level model
module tb_ext_mem_arbiter;
    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
        int          gap;
    } tx_t;
    typedef struct {
        bit          id;
        logic [31:0] data;
    } rsp_t;

    logic clk_i = 1'b0;
    logic rst_i;
    logic i_req_i, i_gnt_o, i_rvalid_o;
    logic [31:0] i_addr_i, i_rdata_o;
    logic d_req_i, d_we_i, d_gnt_o, d_rvalid_o;
    logic [3:0] d_be_i;
    logic [31:0] d_addr_i, d_wdata_i, d_rdata_o;
    logic mem_req_o, write_enable_o, ready_i;
    logic [3:0] byte_enable_o;
    logic [31:0] addr_o, write_data_o, read_data_i;

    logic i_req1, d_req1, ready1;
    logic i_gnt1, i_rv1, d_gnt1, d_rv1, mreq1, we1;
    logic [3:0] be1;
    logic [31:0] i_rd1, d_rd1, addr1, wd1;

    logic [31:0] mem [0:63];
    logic [31:0] ref_mem [0:63];
    tx_t  i_txq[$], d_txq[$];
    rsp_t rsp_q[$];
    bit   gnt_log[$];
    logic [31:0] last_i, last_d;
    bit   m_last = 1'b1, m_lock = 1'b0, m_lock_id = 1'b0;
    bit   i_ok, d_ok;
    int   ready_mode = 1;
    int   errors = 0, checks = 0;

    ext_mem_arbiter #(.RR_EN(1'b1), .ADDR_W(32)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .i_req_i(i_req_i), .i_addr_i(i_addr_i), .i_gnt_o(i_gnt_o), .i_rvalid_o(i_rvalid_o), .i_rdata_o(i_rdata_o),
        .d_req_i(d_req_i), .d_we_i(d_we_i), .d_be_i(d_be_i), .d_addr_i(d_addr_i), .d_wdata_i(d_wdata_i),
        .d_gnt_o(d_gnt_o), .d_rvalid_o(d_rvalid_o), .d_rdata_o(d_rdata_o),
        .mem_req_o(mem_req_o), .write_enable_o(write_enable_o), .byte_enable_o(byte_enable_o),
        .addr_o(addr_o), .write_data_o(write_data_o), .read_data_i(read_data_i), .ready_i(ready_i)
    );

    ext_mem_arbiter #(.RR_EN(1'b0), .ADDR_W(32)) dut_fixed (
        .clk_i(clk_i), .rst_i(rst_i),
        .i_req_i(i_req1), .i_addr_i(32'h40), .i_gnt_o(i_gnt1), .i_rvalid_o(i_rv1), .i_rdata_o(i_rd1),
        .d_req_i(d_req1), .d_we_i(1'b0), .d_be_i(4'hF), .d_addr_i(32'h80), .d_wdata_i(32'h0),
        .d_gnt_o(d_gnt1), .d_rvalid_o(d_rv1), .d_rdata_o(d_rd1),
        .mem_req_o(mreq1), .write_enable_o(we1), .byte_enable_o(be1),
        .addr_o(addr1), .write_data_o(wd1), .read_data_i(32'h0), .ready_i(ready1)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %h expected %h", n, a, e);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk_i);
        #2;
    endtask

    task automatic push_i(input logic [31:0] a, input int g);
        tx_t t;
        t.addr = a; t.we = 1'b0; t.be = 4'h0; t.wdata = 32'h0; t.gap = g;
        i_txq.push_back(t);
    endtask

    task automatic push_d(input logic [31:0] a, input logic we, input logic [3:0] be, input logic [31:0] wd, input int g);
        tx_t t;
        t.addr = a; t.we = we; t.be = be; t.wdata = wd; t.gap = g;
        d_txq.push_back(t);
    endtask

    function automatic logic [31:0] rnd_addr();
        logic [31:0] a;
        a = $urandom_range(0, 63) << 2;
        if ($urandom_range(0, 15) == 0) a = a + 32'h1000;
        return a;
    endfunction

    task automatic drain();
        int n = 0;
        while ((i_txq.size() != 0 || d_txq.size() != 0 || i_req_i || d_req_i || rsp_q.size() != 0) && n < 5000) begin
            step(1);
            n++;
        end
        if (n >= 5000) chk("drain_timeout", 64'(n), 0);
        step(2);
    endtask

    // external memory: registered read, byte-enabled write, fixed patterns for writes and unmapped addresses
    always @(posedge clk_i) begin
        if (mem_req_o && ready_i) begin
            if (write_enable_o) begin
                if (addr_o < 256)
                    for (int b = 0; b < 4; b++)
                        if (byte_enable_o[b]) mem[addr_o[7:2]][8*b +: 8] <= write_data_o[8*b +: 8];
                read_data_i <= 32'hfa11_1eaf;
            end else begin
                read_data_i <= (addr_o < 256) ? mem[addr_o[7:2]] : 32'hdead_beef;
            end
        end
    end

    initial begin
        ready_i = 1'b0;
        forever begin
            @(posedge clk_i); #1;
            ready_i = (ready_mode == 0) ? ($urandom_range(0, 3) != 0) : (ready_mode == 1);
        end
    end

    initial begin
        tx_t t;
        i_req_i = 1'b0; i_addr_i = 32'h0; i_ok = 1'b0;
        forever begin
            @(posedge clk_i); #1;
            if (!i_req_i || i_ok) begin
                i_req_i = 1'b0;
                if (i_txq.size() != 0) begin
                    t = i_txq[0];
                    if (t.gap > 0) begin
                        t.gap--;
                        i_txq[0] = t;
                    end else begin
                        t = i_txq.pop_front();
                        i_req_i = 1'b1; i_addr_i = t.addr;
                    end
                end
            end
            @(negedge clk_i);
            i_ok = i_gnt_o;
        end
    end

    initial begin
        tx_t t;
        d_req_i = 1'b0; d_we_i = 1'b0; d_be_i = 4'h0; d_addr_i = 32'h0; d_wdata_i = 32'h0; d_ok = 1'b0;
        forever begin
            @(posedge clk_i); #1;
            if (!d_req_i || d_ok) begin
                d_req_i = 1'b0;
                if (d_txq.size() != 0) begin
                    t = d_txq[0];
                    if (t.gap > 0) begin
                        t.gap--;
                        d_txq[0] = t;
                    end else begin
                        t = d_txq.pop_front();
                        d_req_i = 1'b1; d_we_i = t.we; d_be_i = t.be; d_addr_i = t.addr; d_wdata_i = t.wdata;
                    end
                end
            end
            @(negedge clk_i);
            d_ok = d_gnt_o;
        end
    end

    // monitor: check responses against the scoreboard, then check arbitration and queue the next expected response
    always @(negedge clk_i) begin
        bit any, sel, acc;
        rsp_t r;
        logic [31:0] a;
        if (rst_i) begin
            chk("rst_ctl", {i_gnt_o, d_gnt_o, i_rvalid_o, d_rvalid_o, mem_req_o, write_enable_o, byte_enable_o}, 0);
            chk("rst_bus", {addr_o, write_data_o}, 0);
            chk("rst_rdata", {i_rdata_o, d_rdata_o}, 0);
            m_last = 1'b1; m_lock = 1'b0;
            rsp_q.delete();
        end else begin
            if (i_rvalid_o || d_rvalid_o) begin
                if (rsp_q.size() == 0) chk("rsp_unexpected", {i_rvalid_o, d_rvalid_o}, 0);
                else begin
                    r = rsp_q.pop_front();
                    chk("rsp_port", {i_rvalid_o, d_rvalid_o}, r.id ? 2'b01 : 2'b10);
                    chk("rsp_data", r.id ? d_rdata_o : i_rdata_o, r.data);
                    chk("rsp_other_rdata", r.id ? i_rdata_o : d_rdata_o, 0);
                    if (r.id) last_d = d_rdata_o; else last_i = i_rdata_o;
                end
            end
            if (rsp_q.size() != 0) begin
                chk("rsp_missing", {i_rvalid_o, d_rvalid_o}, rsp_q[0].id ? 2'b01 : 2'b10);
                rsp_q.delete();
            end
            if (m_lock) chk("req_held_until_gnt", m_lock_id ? d_req_i : i_req_i, 1);
            any = m_lock || i_req_i || d_req_i;
            sel = m_lock ? m_lock_id : (i_req_i && d_req_i) ? !m_last : d_req_i;
            chk("mem_req", mem_req_o, any);
            if (any) begin
                chk("bus_ctl", {write_enable_o, byte_enable_o}, sel ? {d_we_i, d_be_i} : 5'h0F);
                chk("bus_addr", addr_o, sel ? d_addr_i : i_addr_i);
                chk("bus_wdata", write_data_o, sel ? d_wdata_i : 32'h0);
            end else begin
                chk("bus_idle", {addr_o, write_data_o}, 0);
            end
            acc = any && ready_i;
            chk("gnt", {i_gnt_o, d_gnt_o}, {acc && !sel, acc && sel});
            if (acc) begin
                a = sel ? d_addr_i : i_addr_i;
                r.id = sel;
                if (sel && d_we_i) begin
                    if (a < 256)
                        for (int b = 0; b < 4; b++)
                            if (d_be_i[b]) ref_mem[a[7:2]][8*b +: 8] = d_wdata_i[8*b +: 8];
                    r.data = 32'hfa11_1eaf;
                end else begin
                    r.data = (a < 256) ? ref_mem[a[7:2]] : 32'hdead_beef;
                end
                rsp_q.push_back(r);
                gnt_log.push_back(sel);
                m_last = sel; m_lock = 1'b0;
            end else if (any) begin
                m_lock = 1'b1; m_lock_id = sel;
            end
        end
    end

    initial begin
        int n;
        rst_i = 1'b1; i_req1 = 1'b0; d_req1 = 1'b0; ready1 = 1'b1;
        for (int k = 0; k < 64; k++) mem[k] = $urandom;
        mem[2] = 32'h0;
        mem[4] = 32'h1234_5678;
        ref_mem = mem;
        step(3);
        for (int k = 0; k < 4; k++) begin
            push_i($urandom_range(0, 63) << 2, 0);
            push_d($urandom_range(0, 63) << 2, 1'b0, 4'hF, 32'h0, 0);
        end
        gnt_log.delete();
        rst_i = 1'b0;
        drain();
        chk("rr_count", 64'(gnt_log.size()), 8);
        for (int k = 0; k < 4; k++) chk($sformatf("rr_order%0d", k), gnt_log[k], k % 2);

        push_i(32'd16, 0);
        drain();
        chk("i_read_mem4", last_i, 32'h1234_5678);

        push_d(32'd8, 1'b1, 4'b0010, 32'hAABB_CCDD, 0);
        push_d(32'd8, 1'b0, 4'hF, 32'h0, 0);
        drain();
        chk("d_byte_write_read", last_d, 32'h0000_CC00);

        gnt_log.delete();
        ready_mode = 2;
        push_i(32'h20, 0);
        step(3);
        push_d(32'h24, 1'b0, 4'hF, 32'h0, 0);
        step(3);
        ready_mode = 1;
        drain();
        chk("stall_first_instr", gnt_log[0], 0);
        chk("stall_then_data", gnt_log[1], 1);

        gnt_log.delete();
        push_i(32'h30, 0);
        n = 0;
        while (gnt_log.size() == 0 && n < 50) begin
            @(negedge clk_i); #1;
            n++;
        end
        if (n >= 50) chk("rst_wait_timeout", 64'(n), 0);
        @(posedge clk_i); #1;
        rst_i = 1'b1;
        step(1);
        push_i(32'h34, 0);
        push_d(32'h38, 1'b0, 4'hF, 32'h0, 0);
        gnt_log.delete();
        rst_i = 1'b0;
        drain();
        chk("rst_then_instr", gnt_log[0], 0);
        chk("rst_then_data", gnt_log[1], 1);

        i_req1 = 1'b1; d_req1 = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk_i);
            chk($sformatf("fixed_gnt%0d", k), {i_gnt1, d_gnt1}, 2'b01);
        end
        step(1);
        d_req1 = 1'b0;
        @(negedge clk_i);
        chk("fixed_instr_alone", {i_gnt1, d_gnt1}, 2'b10);
        step(1);
        i_req1 = 1'b0;

        ready_mode = 0;
        for (int k = 0; k < 150; k++) begin
            push_i(rnd_addr(), $urandom_range(0, 3));
            push_d(rnd_addr(), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom, $urandom_range(0, 3));
        end
        drain();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
